// File: rtl/pipelined_mult_stream_pkg.sv
// Shared geometry helpers and the stage record layout for the streaming multiplier.
package pipelined_mult_stream_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_STAGES = 4;
    localparam int DEF_TAG_W  = 4;
    localparam int SLICE      = DEF_WIDTH / DEF_STAGES;

    // Record carried between stages at the default geometry; modules carry the
    // same fields as separate arrays sized by their own parameters.
    typedef struct packed {
        logic                     valid;
        logic                     sign;
        logic [DEF_WIDTH-1:0]     a_mag;
        logic [DEF_WIDTH-1:0]     b_mag;
        logic [2*DEF_WIDTH-1:0]   sum;
        logic [DEF_TAG_W-1:0]     tag;
    } stage_t;

    function automatic bit geometry_ok(int width, int stages);
        return (stages > 0) && (width >= 4) && (width % 2 == 0) && (width % stages == 0);
    endfunction

    function automatic int slice_of(int width, int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/pipelined_mult_stream_pp_stage.sv
// One registered partial-product stage: folds SLICE multiplier bits into the running sum.
module mult_pp_stage
    import pipelined_mult_stream_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int TAG_W = DEF_TAG_W,
    parameter int SLICE = DEF_WIDTH / DEF_STAGES,
    parameter int BASE  = 0,
    parameter bit FINAL = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 prev_valid,
    input  logic                 prev_sign,
    input  logic [WIDTH-1:0]     prev_a,
    input  logic [WIDTH-1:0]     prev_b,
    input  logic [2*WIDTH-1:0]   prev_sum,
    input  logic [TAG_W-1:0]     prev_tag,
    output logic                 valid,
    output logic                 sign,
    output logic [WIDTH-1:0]     a_mag,
    output logic [WIDTH-1:0]     b_mag,
    output logic [2*WIDTH-1:0]   sum,
    output logic [TAG_W-1:0]     tag
);

    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] nxt;

    assign ext_a = {{WIDTH{1'b0}}, prev_a};

    always_comb begin
        acc = prev_sum;
        for (int j = 0; j < SLICE; j++) begin
            if (prev_b[BASE+j]) acc = acc + (ext_a << (BASE + j));
        end
        // The last stage applies the sign so the result leaves straight from a register.
        nxt = (FINAL && prev_sign) ? -acc : acc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            sign  <= 1'b0;
            a_mag <= '0;
            b_mag <= '0;
            sum   <= '0;
            tag   <= '0;
        end else if (en) begin
            valid <= prev_valid;
            sign  <= prev_sign;
            a_mag <= prev_a;
            b_mag <= prev_b;
            sum   <= nxt;
            tag   <= prev_tag;
        end
    end

endmodule

// File: rtl/pipelined_mult_stream.sv
// Streaming signed/unsigned multiplier: operand capture, STAGES partial-product stages, global stall.
module pipelined_mult_stream
    import pipelined_mult_stream_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES,
    parameter int TAG_W  = DEF_TAG_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   res,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int SL = slice_of(WIDTH, STAGES);

    if (!geometry_ok(WIDTH, STAGES)) begin : g_bad_geometry
        $error("pipelined_mult_stream: WIDTH must be even, >= 4 and divisible by STAGES");
    end

    logic                          adv;
    logic [STAGES:0]               vld_pipe;
    logic [STAGES:0]               sign_pipe;
    logic [STAGES:0][WIDTH-1:0]    a_pipe;
    logic [STAGES:0][WIDTH-1:0]    b_pipe;
    logic [STAGES:0][2*WIDTH-1:0]  sum_pipe;
    logic [STAGES:0][TAG_W-1:0]    tag_pipe;

    logic                          s0_valid;
    logic                          s0_sign;
    logic [WIDTH-1:0]              s0_a;
    logic [WIDTH-1:0]              s0_b;
    logic [TAG_W-1:0]              s0_tag;

    // Whole pipeline moves together; a free output slot or a draining consumer lets it step.
    assign adv      = !vld_pipe[STAGES] || out_ready;
    assign in_ready = adv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_valid <= 1'b0;
            s0_sign  <= 1'b0;
            s0_a     <= '0;
            s0_b     <= '0;
            s0_tag   <= '0;
        end else if (adv) begin
            s0_valid <= in_valid;
            s0_sign  <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            // -(2^(W-1)) negates to itself, which is exactly the unsigned magnitude.
            s0_a     <= (is_signed && a[WIDTH-1]) ? -a : a;
            s0_b     <= (is_signed && b[WIDTH-1]) ? -b : b;
            s0_tag   <= in_tag;
        end
    end

    assign vld_pipe[0]  = s0_valid;
    assign sign_pipe[0] = s0_sign;
    assign a_pipe[0]    = s0_a;
    assign b_pipe[0]    = s0_b;
    assign sum_pipe[0]  = '0;
    assign tag_pipe[0]  = s0_tag;

    for (genvar k = 1; k <= STAGES; k++) begin : g_stage
        mult_pp_stage #(
            .WIDTH (WIDTH),
            .TAG_W (TAG_W),
            .SLICE (SL),
            .BASE  ((k-1)*SL),
            .FINAL (k == STAGES)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .en         (adv),
            .prev_valid (vld_pipe[k-1]),
            .prev_sign  (sign_pipe[k-1]),
            .prev_a     (a_pipe[k-1]),
            .prev_b     (b_pipe[k-1]),
            .prev_sum   (sum_pipe[k-1]),
            .prev_tag   (tag_pipe[k-1]),
            .valid      (vld_pipe[k]),
            .sign       (sign_pipe[k]),
            .a_mag      (a_pipe[k]),
            .b_mag      (b_pipe[k]),
            .sum        (sum_pipe[k]),
            .tag        (tag_pipe[k])
        );
    end

    assign out_valid = vld_pipe[STAGES];
    assign res       = sum_pipe[STAGES];
    assign out_tag   = tag_pipe[STAGES];

    // Magnitudes and sign of the final stage have no consumer.
    logic unused_tail;
    assign unused_tail = ^{a_pipe[STAGES], b_pipe[STAGES], sign_pipe[STAGES]};

endmodule

// File: tb/tb_pipelined_mult_stream.sv
// Scoreboard bench for pipelined_mult_stream at WIDTH=32, STAGES=4, TAG_W=4.
module tb_pipelined_mult_stream;

    localparam int W  = 32;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, is_signed, out_valid, out_ready;
    logic [W-1:0]  a, b;
    logic [TW-1:0] in_tag, out_tag;
    logic [2*W-1:0] res;

    pipelined_mult_stream #(.WIDTH(W), .STAGES(4), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .is_signed(is_signed), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .res(res), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*W-1:0] res;
        logic [TW-1:0]  tag;
    } exp_t;

    exp_t           sb[$];
    exp_t           e;
    int             checks = 0;
    int             failures = 0;
    logic           acc, con, s_vld;
    logic [2*W-1:0] s_res;
    logic [TW-1:0]  s_tag;

    function automatic logic [2*W-1:0] model(logic [W-1:0] x, logic [W-1:0] y, logic s);
        logic signed [2*W-1:0] sx, sy;
        if (s) begin
            sx = $signed(x);
            sy = $signed(y);
            return sx * sy;
        end
        return {{W{1'b0}}, x} * {{W{1'b0}}, y};
    endfunction

    // Samples handshake state late in the cycle, pushes accepted beats, then steps one edge.
    task automatic tick();
        #2;
        acc   = in_valid && in_ready;
        con   = out_valid && out_ready;
        s_vld = out_valid;
        s_res = res;
        s_tag = out_tag;
        if (acc) begin
            e.res = model(a, b, is_signed);
            e.tag = in_tag;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
        checks++; if (res !== '0) begin failures++; $display("FAIL reset_res got=%h want=0", res); end
        checks++; if (out_tag !== '0) begin failures++; $display("FAIL reset_out_tag got=%h want=0", out_tag); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_latency();
        int lat;
        out_ready = 1'b1;
        a = 32'hFFFF_FFFB; b = 32'd4; is_signed = 1'b1; in_tag = 4'hA; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        for (int n = 1; n < 20; n++) begin
            if (out_valid) begin lat = n; break; end
            tick();
        end
        checks++; if (lat != 5) begin failures++; $display("FAIL latency got=%0d want=5", lat); end
        tick();
        checks++;
        if (!con || sb.size() == 0) begin
            failures++; $display("FAIL latency_consume got=%0b want=1", con);
        end else begin
            e = sb.pop_front();
            if (s_res !== 64'hFFFF_FFFF_FFFF_FFEC || s_tag !== 4'hA) begin
                failures++; $display("FAIL latency_res got=%h/%h want=ffffffffffffffec/a", s_res, s_tag);
            end
        end
    endtask

    task automatic test_corners();
        logic [W-1:0]   ca [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 32'hFFFF_FFF9, 32'h8000_0000, 32'd7};
        logic [W-1:0]   cb [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFF9, 32'h0, 32'd1, 32'd3};
        logic           cs [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [2*W-1:0] cx [7] = '{64'hFFFF_FFFE_0000_0001, 64'h1, 64'h4000_0000_0000_0000,
                                   64'h0, 64'h0, 64'hFFFF_FFFF_8000_0000, 64'd21};
        int sent = 0, got = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 100 && got < 7; cyc++) begin
            in_valid = (sent < 7);
            if (sent < 7) begin a = ca[sent]; b = cb[sent]; is_signed = cs[sent]; in_tag = 4'(sent); end
            tick();
            if (acc) sent++;
            if (con) begin
                checks++;
                if (sb.size() != 0) e = sb.pop_front();
                if (s_res !== cx[got] || s_tag !== 4'(got)) begin
                    failures++; $display("FAIL corner_%0d got=%h/%h want=%h/%h", got, s_res, s_tag, cx[got], 4'(got));
                end
                got++;
            end
        end
        in_valid = 1'b0;
        checks++; if (got != 7) begin failures++; $display("FAIL corner_count got=%0d want=7", got); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]   ra [20];
        logic [W-1:0]   rb [20];
        logic           rs [20];
        logic           hold = 1'b0;
        logic [2*W-1:0] hres = '0;
        logic [TW-1:0]  htag = '0;
        int sent = 0, got = 0;
        for (int i = 0; i < 20; i++) begin
            ra[i] = $urandom; rb[i] = $urandom; rs[i] = 1'($urandom_range(0, 1));
        end
        ra[3] = 32'h8000_0000; rb[3] = 32'hFFFF_FFFF;
        for (int cyc = 0; cyc < 500 && got < 20; cyc++) begin
            in_valid = (sent < 20);
            if (sent < 20) begin a = ra[sent]; b = rb[sent]; is_signed = rs[sent]; in_tag = 4'(sent % 16); end
            out_ready = 1'($urandom_range(0, 1));
            tick();
            if (hold) begin
                checks++;
                if (!s_vld || s_res !== hres || s_tag !== htag) begin
                    failures++; $display("FAIL stall_stable got=%0b/%h/%h want=1/%h/%h", s_vld, s_res, s_tag, hres, htag);
                end
            end
            hold = s_vld && !con;
            hres = s_res; htag = s_tag;
            if (acc) sent++;
            if (con) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++; $display("FAIL stream_extra got=%h want=none", s_res);
                end else begin
                    e = sb.pop_front();
                    if (s_res !== e.res || s_tag !== e.tag) begin
                        failures++; $display("FAIL stream_%0d got=%h/%h want=%h/%h", got, s_res, s_tag, e.res, e.tag);
                    end
                end
                got++;
            end
        end
        in_valid = 1'b0;
        checks++; if (got != 20 || sb.size() != 0) begin failures++; $display("FAIL stream_count got=%0d left=%0d want=20/0", got, sb.size()); end
    endtask

    task automatic test_stall();
        int accepted = 0, got = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; a = 32'(i + 1); b = 32'(i + 3); is_signed = 1'(i); in_tag = 4'(i);
            tick();
            if (acc) accepted++;
        end
        in_valid = 1'b0;
        checks++; if (accepted != 5) begin failures++; $display("FAIL stall_accepted got=%0d want=5", accepted); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready got=%0b want=0", in_ready); end
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && sb.size() != 0; cyc++) begin
            tick();
            if (con) begin
                e = sb.pop_front();
                checks++;
                if (s_res !== e.res || s_tag !== e.tag || s_tag !== 4'(got)) begin
                    failures++; $display("FAIL drain_%0d got=%h/%h want=%h/%h", got, s_res, s_tag, e.res, e.tag);
                end
                got++;
            end
        end
        checks++; if (got != 5) begin failures++; $display("FAIL drain_count got=%0d want=5", got); end
    endtask

    task automatic test_reset_mid();
        int stale = 0, lat = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = 32'(100 + i); b = 32'd9; is_signed = 1'b0; in_tag = 4'(5 + i);
            tick();
        end
        in_valid = 1'b0;
        tick(); tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL pre_reset_valid got=%0b want=1", out_valid); end
        #1 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || res !== '0) begin failures++; $display("FAIL mid_reset got=%0b/%h want=0/0", out_valid, res); end
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (s_vld) stale++;
        end
        checks++; if (stale != 0) begin failures++; $display("FAIL stale_beats got=%0d want=0", stale); end
        a = 32'hFFFF_FFFD; b = 32'd6; is_signed = 1'b1; in_tag = 4'h3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int n = 1; n < 20; n++) begin
            if (out_valid) begin lat = n; break; end
            tick();
        end
        checks++; if (lat != 5) begin failures++; $display("FAIL post_reset_latency got=%0d want=5", lat); end
        tick();
        checks++;
        if (!con || s_res !== 64'hFFFF_FFFF_FFFF_FFEE || s_tag !== 4'h3) begin
            failures++; $display("FAIL post_reset_res got=%0b/%h/%h want=1/ffffffffffffffee/3", con, s_res, s_tag);
        end
    endtask

    initial begin
        in_valid = 1'b0; a = '0; b = '0; is_signed = 1'b0; in_tag = '0; out_ready = 1'b0;
        test_reset();
        test_latency();
        test_corners();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
